// File: rtl/detector_jogada.sv
// Button conditioner for the memory game: synchronises and debounces the raw
// buttons and issues one jogada strobe per physical push, flagging chords.
module detector_jogada #(
   parameter int N_BOTOES = 4,
   parameter int DEBOUNCE = 50000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [N_BOTOES-1:0] botoes,
   output logic                jogada,
   output logic [N_BOTOES-1:0] jogada_valor,
   output logic                multiplos,
   output logic [2:0]          db_estado
);

   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

   typedef enum logic [2:0] {
      REPOUSO      = 3'd0,
      FILTRA       = 3'd1,
      ACEITA       = 3'd2,
      ESPERA_SOLTA = 3'd3,
      SOLTANDO     = 3'd4
   } estado_t;

   estado_t             estado;
   logic [N_BOTOES-1:0] sync1;
   logic [N_BOTOES-1:0] s;
   logic [N_BOTOES-1:0] c;
   logic [CW-1:0]       cnt;
   logic                valido;

   function automatic logic isOneHot(input logic [N_BOTOES-1:0] v);
      return $countones(v) == 1;
   endfunction

   // Synchroniser, press/release filter and strobe state machine; the counter
   // is cleared on every entry to a filtering state so it can never wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1        <= '0;
         s            <= '0;
         c            <= '0;
         cnt          <= '0;
         valido       <= 1'b0;
         jogada_valor <= '0;
         estado       <= REPOUSO;
      end else begin
         sync1 <= botoes;
         s     <= sync1;
         case (estado)
            REPOUSO: begin
               if (s != '0) begin
                  estado <= FILTRA;
                  c      <= s;
                  cnt    <= '0;
               end
            end
            FILTRA: begin
               if (s != c) begin
                  estado <= REPOUSO;
                  cnt    <= '0;
               end else if (cnt == CNT_MAX) begin
                  estado <= ACEITA;
                  valido <= enable && isOneHot(c);
                  if (enable && isOneHot(c)) begin
                     jogada_valor <= c;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ACEITA: begin
               estado <= ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
               if (s == '0) begin
                  estado <= SOLTANDO;
                  cnt    <= '0;
               end
            end
            SOLTANDO: begin
               if (s != '0) begin
                  estado <= ESPERA_SOLTA;
               end else if (cnt == CNT_MAX) begin
                  estado <= REPOUSO;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               estado <= REPOUSO;
            end
         endcase
      end
   end

   assign jogada    = (estado == ACEITA) && valido;
   assign multiplos = (estado == ACEITA) && !isOneHot(c);
   assign db_estado = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed scenarios followed by random presses with
// bounce, checked cycle by cycle against a timing model of the press rules.
module tb_detector_jogada;

   localparam int N = 4;
   localparam int D = 4;

   logic         clock;
   logic         reset;
   logic         enable;
   logic [N-1:0] botoes;
   logic         jogada;
   logic [N-1:0] jogada_valor;
   logic         multiplos;
   logic [2:0]   db_estado;

   int           errors;
   int           checks;
   int           edgeCount;
   int           schedEdge;
   logic         schedJog;
   logic         schedMul;
   logic [N-1:0] schedVal;
   logic [N-1:0] modelValor;

   detector_jogada #(.N_BOTOES(N), .DEBOUNCE(D)) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .botoes       (botoes),
      .jogada       (jogada),
      .jogada_valor (jogada_valor),
      .multiplos    (multiplos),
      .db_estado    (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compares every output against the model for the edge just taken.
   task automatic checkOutput(input int expState);
      logic expJ;
      logic expM;
      expJ = (edgeCount == schedEdge) && schedJog;
      expM = (edgeCount == schedEdge) && schedMul;
      if (expJ) modelValor = schedVal;
      checks++;
      assert (jogada === expJ) else begin
         errors++;
         $error("FAIL jogada edge=%0d observed=%b expected=%b", edgeCount, jogada, expJ);
      end
      checks++;
      assert (multiplos === expM) else begin
         errors++;
         $error("FAIL multiplos edge=%0d observed=%b expected=%b", edgeCount, multiplos, expM);
      end
      checks++;
      assert (jogada_valor === modelValor) else begin
         errors++;
         $error("FAIL jogada_valor edge=%0d observed=%b expected=%b", edgeCount, jogada_valor, modelValor);
      end
      if (expState >= 0) begin
         checks++;
         assert (db_estado === 3'(expState)) else begin
            errors++;
            $error("FAIL db_estado edge=%0d observed=%0d expected=%0d", edgeCount, db_estado, expState);
         end
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] v, input int expState);
      botoes = v;
      @(posedge clock);
      edgeCount++;
      @(negedge clock);
      checkOutput(expState);
   endtask

   // Stable press starting at the next edge: accepted D+2 edges later.
   task automatic doPress(input logic [N-1:0] v, input int hold);
      int ones;
      ones = 0;
      for (int b = 0; b < N; b++) if (v[b]) ones++;
      schedEdge = edgeCount + 1 + D + 2;
      schedJog  = enable && (ones == 1);
      schedMul  = (ones != 1);
      schedVal  = v;
      for (int i = 0; i < hold; i++) begin
         if (i < 2)          applyStimulus(v, -1);
         else if (i < D + 2) applyStimulus(v, 1);
         else if (i == D + 2) applyStimulus(v, 2);
         else                applyStimulus(v, 3);
      end
   endtask

   task automatic doRelease(input int gap);
      for (int i = 0; i < gap; i++) begin
         if (i < 2)          applyStimulus('0, -1);
         else if (i < D + 2) applyStimulus('0, 4);
         else                applyStimulus('0, 0);
      end
   endtask

   task automatic asyncReset();
      reset      = 1'b1;
      schedEdge  = -1;
      modelValor = '0;
      #1;
      checkOutput(0);
   endtask

   initial begin
      logic [N-1:0] v;
      logic [N-1:0] seq [15];
      int           st  [15];
      errors     = 0;
      checks     = 0;
      edgeCount  = 0;
      schedEdge  = -1;
      schedJog   = 1'b0;
      schedMul   = 1'b0;
      schedVal   = '0;
      modelValor = '0;
      reset      = 1'b1;
      enable     = 1'b1;
      botoes     = 4'b0010;
      @(negedge clock);

      // 1: reset with a button held, then a normal press once released
      for (int i = 0; i < 3; i++) applyStimulus(4'b0010, 0);
      reset = 1'b0;
      doPress(4'b0010, 12);
      doRelease(D + 5);

      // 2: clean press held for 20 cycles
      doPress(4'b0100, 20);
      doRelease(D + 5);

      // 3: bounce then stable hold
      for (int i = 0; i < 10; i++) applyStimulus(((i / 2) % 2 == 1) ? 4'b0001 : 4'b0000, -1);
      doPress(4'b0001, 12);
      doRelease(D + 5);

      // 4: chord
      doPress(4'b0011, 12);
      doRelease(D + 5);

      // 5: disabled press, then enabled press
      enable = 1'b0;
      doPress(4'b1000, 12);
      doRelease(D + 5);
      enable = 1'b1;
      doPress(4'b0001, 12);
      doRelease(D + 5);

      // 6a: one-cycle glitch while in SOLTANDO returns to ESPERA_SOLTA
      doPress(4'b0010, 12);
      st = '{3, 3, 4, 4, 4, 4, 3, 4, 4, 4, 4, 0, 0, 0, 0};
      for (int i = 0; i < 15; i++) seq[i] = (i == 4) ? 4'b0001 : 4'b0000;
      for (int i = 0; i < 15; i++) applyStimulus(seq[i], st[i]);

      // 6b: reset while filtering, button still held afterwards
      for (int i = 0; i < 4; i++) applyStimulus(4'b0100, (i < 2) ? 0 : 1);
      asyncReset();
      for (int i = 0; i < 2; i++) applyStimulus(4'b0100, 0);
      reset = 1'b0;
      doPress(4'b0100, 12);
      doRelease(D + 5);

      // Random presses with bounce on press and release
      for (int n = 0; n < 30; n++) begin
         enable = 1'($urandom % 2);
         if ($urandom % 4 != 0) v = 4'b0001 << ($urandom % 4);
         else                   v = 4'($urandom_range(1, 15));
         for (int p = $urandom % 3; p > 0; p--) begin
            for (int k = $urandom_range(1, D); k > 0; k--) applyStimulus(v, -1);
            for (int k = $urandom_range(1, 3); k > 0; k--) applyStimulus('0, -1);
         end
         doPress(v, D + 4 + int'($urandom % 6));
         for (int p = $urandom % 3; p > 0; p--) begin
            for (int k = $urandom_range(1, 2); k > 0; k--) applyStimulus('0, -1);
            applyStimulus(v, -1);
         end
         doRelease(D + 4 + int'($urandom % 4));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
